// File: rtl/i2s_pkg.sv
// Constants and sizing helpers shared by the I2S transmitter and receiver.
package i2s_pkg;

    // Bits per channel word unless a design overrides it.
    localparam int DEFAULT_DATA_SIZE = 16;

    // One frame carries a left and a right word.
    localparam int DEFAULT_FRAME_LEN = 2 * DEFAULT_DATA_SIZE;

    function automatic int frame_len(input int data_size);
        return 2 * data_size;
    endfunction

    // Width of a counter that spans every slot of one frame.
    function automatic int slot_cnt_width(input int data_size);
        return $clog2(2 * data_size);
    endfunction

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample-pair handshake between a PCM source and the I2S transmitter.
interface i2s_transmitter_if
    import i2s_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE
);
    logic [DATA_SIZE-1:0] sample_left;
    logic [DATA_SIZE-1:0] sample_right;
    logic                 sample_valid;
    logic                 sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_tx_holding.sv
// One-entry valid/ready holding buffer. The consumer empties it with a
// single-cycle take strobe; a take never forwards data accepted on the same edge.
module i2s_tx_holding
    import i2s_pkg::*;
#(
    parameter int WIDTH = DEFAULT_FRAME_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             take,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    logic             full_q;
    logic             ready_q;
    logic [WIDTH-1:0] data_q;
    logic             accept;
    logic             full_nxt;

    assign accept = in_valid && ready_q;

    // A take clears the entry; an accept on the same edge refills it.
    always_comb begin
        full_nxt = full_q || accept;
        if (take) begin
            full_nxt = accept;
        end
    end

    // Occupancy flag, its registered inverse, and the stored word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            ready_q <= 1'b1;
            data_q  <= '0;
        end else begin
            full_q  <= full_nxt;
            ready_q <= !full_nxt;
            if (accept) begin
                data_q <= in_data;
            end
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = full_q;
    assign out_data  = data_q;
endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter: serialises left/right words MSB first on the bit clock,
// with word select leading the data by one slot.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) (
    input  logic               clk,
    input  logic               rst_n,
    i2s_transmitter_if.slave   bus,
    output logic               i2s_sd,
    output logic               i2s_ws,
    output logic               underrun
);
    localparam int FRAME_LEN = frame_len(DATA_SIZE);
    localparam int CNT_W     = slot_cnt_width(DATA_SIZE);

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] WS_FIRST  = CNT_W'(DATA_SIZE - 1);
    localparam logic [CNT_W-1:0] WS_LAST   = CNT_W'(FRAME_LEN - 2);

    logic [CNT_W-1:0]     slot_cnt;
    logic [CNT_W-1:0]     slot_nxt;
    logic                 wrap;
    logic                 ws_nxt;
    logic                 ws_q;
    logic                 underrun_q;
    logic [FRAME_LEN-1:0] shift_q;
    logic                 hold_valid;
    logic [FRAME_LEN-1:0] hold_data;

    i2s_tx_holding #(
        .WIDTH (FRAME_LEN)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   ({bus.sample_left, bus.sample_right}),
        .in_valid  (bus.sample_valid),
        .in_ready  (bus.sample_ready),
        .take      (wrap),
        .out_valid (hold_valid),
        .out_data  (hold_data)
    );

    assign wrap = (slot_cnt == LAST_SLOT);

    // Next slot index and the word select that belongs to it.
    always_comb begin
        slot_nxt = slot_cnt + 1'b1;
        if (wrap) begin
            slot_nxt = '0;
        end
        ws_nxt = (slot_nxt >= WS_FIRST) && (slot_nxt <= WS_LAST);
    end

    // Free-running slot counter; word select is registered one slot ahead of data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            ws_q     <= 1'b0;
        end else begin
            slot_cnt <= slot_nxt;
            ws_q     <= ws_nxt;
        end
    end

    // Frame shifter: load a fresh pair (or silence) at the wrap, else shift out MSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= wrap && !hold_valid;
            if (wrap) begin
                shift_q <= hold_valid ? hold_data : '0;
            end else begin
                shift_q <= {shift_q[FRAME_LEN-2:0], 1'b0};
            end
        end
    end

    assign i2s_sd   = shift_q[FRAME_LEN-1];
    assign i2s_ws   = ws_q;
    assign underrun = underrun_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter at DATA_SIZE=16 against a frame-level model.
module tb_i2s_transmitter;
    import i2s_pkg::*;

    localparam int N     = 16;
    localparam int FRAME = 2 * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic i2s_sd;
    logic i2s_ws;
    logic underrun;

    int tests = 0;
    int fails = 0;

    i2s_transmitter_if #(.DATA_SIZE(N)) bus();

    i2s_transmitter #(.DATA_SIZE(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .i2s_sd   (i2s_sd),
        .i2s_ws   (i2s_ws),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    // Frame-level reference: the word on the wire this frame, and a one-deep pending pair.
    int               m_slot;
    logic [FRAME-1:0] m_frame;
    logic [FRAME-1:0] m_hold;
    logic             m_full;
    logic             m_underrun;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_slot     <= 0;
            m_frame    <= '0;
            m_hold     <= '0;
            m_full     <= 1'b0;
            m_underrun <= 1'b0;
        end else begin
            m_slot <= (m_slot + 1) % FRAME;
            if (m_slot == FRAME - 1) begin
                m_frame    <= m_full ? m_hold : '0;
                m_underrun <= !m_full;
                m_full     <= bus.sample_valid && !m_full;
            end else begin
                m_underrun <= 1'b0;
                if (bus.sample_valid && !m_full) m_full <= 1'b1;
            end
            if (bus.sample_valid && !m_full) m_hold <= {bus.sample_left, bus.sample_right};
        end
    end

    function automatic logic exp_sd();
        return m_frame[FRAME - 1 - m_slot];
    endfunction

    // Word select is high when the following slot belongs to the right word.
    function automatic logic exp_ws();
        return ((m_slot + 1) % FRAME) >= N;
    endfunction

    task automatic wait_slot(input int s);
        int n;
        n = 0;
        @(negedge clk);
        while (m_slot != s && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (m_slot != s) begin
            tests++; fails++;
            $display("FAIL wait_slot: timed out at slot %0d, wanted %0d", m_slot, s);
        end
    endtask

    // Called on the slot-0 negedge; samples one whole frame.
    task automatic capture_frame(output logic [FRAME-1:0] w, output logic [FRAME-1:0] wsv,
                                 output logic ur0);
        ur0 = underrun;
        for (int s = 0; s < FRAME; s++) begin
            if (s > 0) @(negedge clk);
            w[FRAME - 1 - s] = i2s_sd;
            wsv[s]           = i2s_ws;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_left  = '0;
        bus.sample_right = '0;
        repeat (3) begin
            @(negedge clk);
            tests += 4;
            if (i2s_sd !== 1'b0)           begin fails++; $display("FAIL reset_sd: got %b want 0", i2s_sd); end
            if (i2s_ws !== 1'b0)           begin fails++; $display("FAIL reset_ws: got %b want 0", i2s_ws); end
            if (bus.sample_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", bus.sample_ready); end
            if (underrun !== 1'b0)         begin fails++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        end
        rst_n = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            tests += 2;
            if (i2s_sd !== 1'b0) begin fails++; $display("FAIL first_frame_sd: slot %0d got %b want 0", m_slot, i2s_sd); end
            if (underrun !== (m_slot == 0)) begin
                fails++; $display("FAIL first_frame_underrun: slot %0d got %b want %b", m_slot, underrun, m_slot == 0);
            end
        end
    endtask

    task automatic test_known_pair();
        logic [FRAME-1:0] w, wsv;
        logic ur0;
        wait_slot(20);
        tests++;
        if (bus.sample_ready !== 1'b1) begin fails++; $display("FAIL known_ready: got %b want 1", bus.sample_ready); end
        bus.sample_left  = 16'hA5C3;
        bus.sample_right = 16'h8001;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        wait_slot(0);
        capture_frame(w, wsv, ur0);
        tests += 3;
        if (w !== 32'hA5C38001)   begin fails++; $display("FAIL known_data: got %h want a5c38001", w); end
        if (wsv !== 32'h7FFF8000) begin fails++; $display("FAIL known_ws: got %h want 7fff8000", wsv); end
        if (ur0 !== 1'b0)         begin fails++; $display("FAIL known_underrun: got %b want 0", ur0); end
    endtask

    task automatic test_idle();
        int pulses;
        pulses = 0;
        bus.sample_valid = 1'b0;
        wait_slot(0);
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (i > 0) @(negedge clk);
            tests += 3;
            if (i2s_sd !== 1'b0) begin fails++; $display("FAIL idle_sd: slot %0d got %b want 0", m_slot, i2s_sd); end
            if (i2s_ws !== exp_ws()) begin fails++; $display("FAIL idle_ws: slot %0d got %b want %b", m_slot, i2s_ws, exp_ws()); end
            if (underrun !== (m_slot == 0)) begin
                fails++; $display("FAIL idle_underrun: slot %0d got %b want %b", m_slot, underrun, m_slot == 0);
            end
            if (underrun === 1'b1) pulses++;
        end
        tests++;
        if (pulses != 3) begin fails++; $display("FAIL idle_pulse_count: got %0d want 3", pulses); end
    endtask

    task automatic test_back_to_back();
        logic [FRAME-1:0] q[$];
        logic [FRAME-1:0] wbuf, want;
        logic [15:0] base;
        int frames, k, late_underruns;
        logic upd;
        frames = 0; k = 0; late_underruns = 0; upd = 1'b0;
        base = 16'($urandom);
        wait_slot(0);
        bus.sample_left  = base;
        bus.sample_right = ~base;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 6 * FRAME; i++) begin
            if (i > 0) @(negedge clk);
            tests += 4;
            if (i2s_sd !== exp_sd()) begin fails++; $display("FAIL b2b_sd: slot %0d got %b want %b", m_slot, i2s_sd, exp_sd()); end
            if (i2s_ws !== exp_ws()) begin fails++; $display("FAIL b2b_ws: slot %0d got %b want %b", m_slot, i2s_ws, exp_ws()); end
            if (bus.sample_ready !== !m_full) begin
                fails++; $display("FAIL b2b_ready: slot %0d got %b want %b", m_slot, bus.sample_ready, !m_full);
            end
            if (underrun !== m_underrun) begin fails++; $display("FAIL b2b_underrun: slot %0d got %b want %b", m_slot, underrun, m_underrun); end
            if (i > 0 && underrun === 1'b1) late_underruns++;
            wbuf[FRAME - 1 - m_slot] = i2s_sd;
            if (m_slot == FRAME - 1) begin
                frames++;
                if (frames >= 2) begin
                    tests++;
                    if (q.size() == 0) begin
                        fails++; $display("FAIL b2b_order: frame %0d got %h with nothing queued", frames, wbuf);
                    end else begin
                        want = q.pop_front();
                        if (wbuf !== want) begin fails++; $display("FAIL b2b_order: frame %0d got %h want %h", frames, wbuf, want); end
                    end
                end
            end
            if (upd) begin
                k++;
                bus.sample_left  = base + 16'(k);
                bus.sample_right = ~(base + 16'(k));
                upd = 1'b0;
            end
            if (!m_full) begin
                q.push_back({bus.sample_left, bus.sample_right});
                upd = 1'b1;
            end
        end
        bus.sample_valid = 1'b0;
        tests++;
        if (late_underruns != 0) begin fails++; $display("FAIL b2b_no_underrun: got %0d pulses want 0", late_underruns); end
    endtask

    task automatic test_slot31_accept();
        logic [FRAME-1:0] w, wsv, pair;
        logic ur0;
        pair = FRAME'($urandom);
        bus.sample_valid = 1'b0;
        wait_slot(0);
        wait_slot(FRAME - 1);
        {bus.sample_left, bus.sample_right} = pair;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        tests += 2;
        if (bus.sample_ready !== 1'b0) begin fails++; $display("FAIL s31_ready: got %b want 0", bus.sample_ready); end
        capture_frame(w, wsv, ur0);
        if (ur0 !== 1'b1) begin fails++; $display("FAIL s31_underrun: got %b want 1", ur0); end
        tests++;
        if (w !== '0) begin fails++; $display("FAIL s31_silent_frame: got %h want 0", w); end
        @(negedge clk);
        capture_frame(w, wsv, ur0);
        tests += 2;
        if (w !== pair)   begin fails++; $display("FAIL s31_next_frame: got %h want %h", w, pair); end
        if (ur0 !== 1'b0) begin fails++; $display("FAIL s31_next_underrun: got %b want 0", ur0); end
    endtask

    task automatic test_full_ignore();
        logic [FRAME-1:0] w, wsv, x, y;
        logic ur0;
        x = FRAME'($urandom);
        y = ~x;
        wait_slot(3);
        {bus.sample_left, bus.sample_right} = x;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        wait_slot(10);
        tests++;
        if (bus.sample_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", bus.sample_ready); end
        {bus.sample_left, bus.sample_right} = y;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        wait_slot(0);
        capture_frame(w, wsv, ur0);
        tests += 2;
        if (w !== x)      begin fails++; $display("FAIL full_held_data: got %h want %h", w, x); end
        if (ur0 !== 1'b0) begin fails++; $display("FAIL full_held_underrun: got %b want 0", ur0); end
        @(negedge clk);
        capture_frame(w, wsv, ur0);
        tests += 2;
        if (w !== '0)     begin fails++; $display("FAIL full_ignored_pair: got %h want 0", w); end
        if (ur0 !== 1'b1) begin fails++; $display("FAIL full_after_underrun: got %b want 1", ur0); end
    endtask

    task automatic test_random(input int nframes);
        for (int i = 0; i < nframes * FRAME; i++) begin
            @(negedge clk);
            tests += 4;
            if (i2s_sd !== exp_sd()) begin fails++; $display("FAIL rand_sd: slot %0d got %b want %b", m_slot, i2s_sd, exp_sd()); end
            if (i2s_ws !== exp_ws()) begin fails++; $display("FAIL rand_ws: slot %0d got %b want %b", m_slot, i2s_ws, exp_ws()); end
            if (bus.sample_ready !== !m_full) begin
                fails++; $display("FAIL rand_ready: slot %0d got %b want %b", m_slot, bus.sample_ready, !m_full);
            end
            if (underrun !== m_underrun) begin fails++; $display("FAIL rand_underrun: slot %0d got %b want %b", m_slot, underrun, m_underrun); end
            bus.sample_valid = ($urandom_range(0, 5) == 0);
            bus.sample_left  = 16'($urandom);
            bus.sample_right = 16'($urandom);
        end
        bus.sample_valid = 1'b0;
    endtask

    task automatic test_reset_midframe();
        bus.sample_valid = 1'b0;
        wait_slot(0);
        bus.sample_left  = 16'hFFFF;
        bus.sample_right = 16'hFFFF;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        wait_slot(0);
        bus.sample_left  = 16'h1234;
        bus.sample_right = 16'h5678;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        wait_slot(20);
        tests += 3;
        if (i2s_sd !== 1'b1)           begin fails++; $display("FAIL mid_pre_sd: got %b want 1", i2s_sd); end
        if (i2s_ws !== 1'b1)           begin fails++; $display("FAIL mid_pre_ws: got %b want 1", i2s_ws); end
        if (bus.sample_ready !== 1'b0) begin fails++; $display("FAIL mid_pre_ready: got %b want 0", bus.sample_ready); end
        #2 rst_n = 1'b0;
        #1;
        tests += 4;
        if (i2s_sd !== 1'b0)           begin fails++; $display("FAIL mid_rst_sd: got %b want 0", i2s_sd); end
        if (i2s_ws !== 1'b0)           begin fails++; $display("FAIL mid_rst_ws: got %b want 0", i2s_ws); end
        if (bus.sample_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_ready: got %b want 1", bus.sample_ready); end
        if (underrun !== 1'b0)         begin fails++; $display("FAIL mid_rst_underrun: got %b want 0", underrun); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME + 1; i++) begin
            @(negedge clk);
            tests += 3;
            if (i2s_sd !== 1'b0) begin fails++; $display("FAIL mid_lost_pair_sd: slot %0d got %b want 0", m_slot, i2s_sd); end
            if (i2s_ws !== exp_ws()) begin fails++; $display("FAIL mid_ws: slot %0d got %b want %b", m_slot, i2s_ws, exp_ws()); end
            if (underrun !== (m_slot == 0)) begin
                fails++; $display("FAIL mid_underrun: slot %0d got %b want %b", m_slot, underrun, m_slot == 0);
            end
        end
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_left  = '0;
        bus.sample_right = '0;
        test_reset();
        test_known_pair();
        test_idle();
        test_back_to_back();
        test_slot31_accept();
        test_full_ignore();
        test_random(8);
        test_reset_midframe();
        test_random(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 16, meaning bits per channel word (8, 16, 24 or 32).
REQ-002 Port clk SHALL be: input, 1 bit, the serial bit clock; every register updates on its rising edge.
REQ-003 Port rst_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-004 Port sample_left SHALL be: input, DATA_SIZE bits, left-channel word, two's complement.
REQ-005 Port sample_right SHALL be: input, DATA_SIZE bits, right-channel word, two's complement.
REQ-006 Port sample_valid SHALL be: input, 1 bit, high when the left/right pair is presented.
REQ-007 Port sample_ready SHALL be: output, 1 bit, high when the holding register is empty.
REQ-008 Port i2s_sd SHALL be: output, 1 bit, serial data, MSB first.
REQ-009 Port i2s_ws SHALL be: output, 1 bit, word select; 0 = left, 1 = right.
REQ-010 Port underrun SHALL be: output, 1 bit, one-cycle pulse when a frame starts with no pending sample.

Function
REQ-011 A slot counter SHALL count 0..2*DATA_SIZE-1 and wrap to 0; it increments on every clk edge outside reset.
REQ-012 Slots 0..DATA_SIZE-1 SHALL carry the left word and slots DATA_SIZE..2*DATA_SIZE-1 the right word, each MSB first.
REQ-013 i2s_ws SHALL be 1 during slots DATA_SIZE-1..2*DATA_SIZE-2 and 0 otherwise, leading data by one slot.
REQ-014 i2s_sd and i2s_ws SHALL be driven directly from flops; there SHALL be no combinational path from inputs.
REQ-015 A pair SHALL be accepted on an edge where sample_valid and sample_ready are both 1; it is stored in a one-entry holding register.
REQ-016 sample_ready SHALL be registered and equal to the inverse of the holding-full flag.
REQ-017 On the edge where the counter goes 2*DATA_SIZE-1 -> 0, the shift register SHALL load {left, right} from the holding register and clear the full flag.
REQ-018 If the holding register is empty at that edge, the shift register SHALL load all zeros and underrun SHALL be 1 for exactly the following cycle.
REQ-019 Accept and load on the same edge SHALL NOT bypass: when holding is empty, the new pair enters holding, the frame underruns, and the pair goes out in the next frame.
REQ-020 When holding is full, sample_valid SHALL be ignored and the held pair SHALL remain unchanged.
REQ-021 Latency SHALL be as follows: a pair accepted before the wrap edge has its left MSB on i2s_sd during slot 0 of the immediately following frame.
REQ-022 Words SHALL NOT be truncated, padded, rounded or reordered; every frame is exactly 2*DATA_SIZE clk cycles.

Reset
REQ-023 While rst_n = 0, the block SHALL hold i2s_sd=0, i2s_ws=0, sample_ready=1, underrun=0, slot counter=0, shift register=0 and holding empty.
REQ-024 Assertion mid-frame SHALL take effect immediately and discard the partial frame and any held pair.
REQ-025 After release, the first frame SHALL transmit zeros; its wrap edge follows normal load/underrun rules.

Structure
REQ-026 Package i2s_pkg SHALL hold the default DATA_SIZE, the frame-length constant (2*DATA_SIZE) and the slot-counter width function; it is shared with the I2S receiver.
REQ-027 One sub-module, i2s_tx_holding (one-entry valid/ready buffer), SHALL be used; counter, ws and shift logic stay in the top module.

Verification (DATA_SIZE=16)
REQ-028 The bench SHALL cover: assert rst_n=0 mid-frame -> outputs immediately 0/0/ready=1/underrun=0, and the held pair is lost.
REQ-029 The bench SHALL cover: left=16'hA5C3, right=16'h8001 accepted before the wrap -> next frame i2s_sd = A5C3 then 8001 MSB first, with i2s_ws rising at slot 15 and falling at slot 31.
REQ-030 The bench SHALL cover: no sample_valid for 3 frames -> i2s_sd=0 throughout and one underrun pulse per frame, at the cycle after each wrap.
REQ-031 The bench SHALL cover: sample_valid held high with incrementing pairs -> sample_ready is low from accept until the next wrap, and every pair is sent once, in order, with no underrun.
REQ-032 The bench SHALL cover: first pair presented exactly on the slot-31 edge with holding empty -> underrun pulses and the pair appears in the following frame.
REQ-033 The bench SHALL cover: a valid pulse while holding is full -> it is not accepted, and the held data is transmitted unchanged.
